// File: rtl/maxpool_unit.sv
// 2x2 stride-2 signed max pooling over a feature map held in a synchronous-read RAM.
// Each output window takes five cycles: four reads, then one write of the window maximum.
module maxpool_unit #(
  parameter int DATA_W    = 32,
  parameter int FMAP_W    = 6,
  parameter int FMAP_H    = 6,
  parameter int RD_ADDR_W = 6,
  parameter int WR_ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [RD_ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]    rd_data,
  output logic                 wr_en,
  output logic [WR_ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic [2:0]           dbg_state_o
);

  localparam int OUT_W = FMAP_W / 2;
  localparam int OUT_H = FMAP_H / 2;
  localparam int PC_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int PR_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(OUT_W - 1);
  localparam logic [PR_W-1:0] PR_LAST = PR_W'(OUT_H - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_RD2  = 3'd3,
    S_RD3  = 3'd4,
    S_WR   = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t                 state_q;
  logic [PR_W-1:0]        pr_q;
  logic [PC_W-1:0]        pc_q;
  logic [DATA_W-1:0]      acc_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   rd_en_q;
  logic [RD_ADDR_W-1:0]   rd_addr_q;
  logic                   wr_en_q;
  logic [WR_ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]      wr_data_q;
  logic [DATA_W-1:0]      max_d;
  logic [PC_W-1:0]        pc_inc_d;
  logic [PR_W-1:0]        pr_inc_d;

  function automatic logic [RD_ADDR_W-1:0] rd_addr_of(input logic [PR_W-1:0] pr,
                                                      input logic [PC_W-1:0] pc,
                                                      input int dr, input int dc);
    rd_addr_of = RD_ADDR_W'((2 * int'(pr) + dr) * FMAP_W + 2 * int'(pc) + dc);
  endfunction

  // The fourth sample arrives during WR, so the final maximum is formed combinationally there.
  assign max_d    = ($signed(rd_data) > $signed(acc_q)) ? rd_data : acc_q;
  assign pc_inc_d = pc_q + PC_W'(1);
  assign pr_inc_d = pr_q + PR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pr_q      <= '0;
      pc_q      <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
            pr_q      <= '0;
            pc_q      <= '0;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            state_q   <= S_RD0;
          end
        end
        S_RD0: begin
          rd_addr_q <= rd_addr_of(pr_q, pc_q, 0, 1);
          state_q   <= S_RD1;
        end
        S_RD1: begin
          acc_q     <= rd_data;
          rd_addr_q <= rd_addr_of(pr_q, pc_q, 1, 0);
          state_q   <= S_RD2;
        end
        S_RD2: begin
          acc_q     <= max_d;
          rd_addr_q <= rd_addr_of(pr_q, pc_q, 1, 1);
          state_q   <= S_RD3;
        end
        S_RD3: begin
          acc_q     <= max_d;
          rd_en_q   <= 1'b0;
          wr_en_q   <= 1'b1;
          wr_addr_q <= WR_ADDR_W'(int'(pr_q) * OUT_W + int'(pc_q));
          state_q   <= S_WR;
        end
        S_WR: begin
          wr_en_q   <= 1'b0;
          wr_data_q <= max_d;
          if (pc_q < PC_LAST) begin
            pc_q      <= pc_inc_d;
            rd_en_q   <= 1'b1;
            rd_addr_q <= rd_addr_of(pr_q, pc_inc_d, 0, 0);
            state_q   <= S_RD0;
          end else if (pr_q < PR_LAST) begin
            pc_q      <= '0;
            pr_q      <= pr_inc_d;
            rd_en_q   <= 1'b1;
            rd_addr_q <= rd_addr_of(pr_inc_d, '0, 0, 0);
            state_q   <= S_RD0;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_en_q ? max_d : wr_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/maxpool_unit.md
Name: maxpool_unit

Overview:
Downstream stage of the 3x3 convolution engine. After the engine signals done, this block reads the post-ReLU feature map from the engine's output RAM through a synchronous read port. It performs 2x2, stride-2 signed max pooling and writes the pooled map to a result RAM through a write port. With the defaults, a 6x6 map reduces to 3x3 (9 results).

Parameters:
DATA_W, 32, signed element width of the feature map and pooled results
FMAP_W, 6, input feature-map width (columns)
FMAP_H, 6, input feature-map height (rows)
RD_ADDR_W, 6, read address width; must satisfy 2^RD_ADDR_W >= FMAP_W*FMAP_H
WR_ADDR_W, 4, write address width; must satisfy 2^WR_ADDR_W >= (FMAP_W/2)*(FMAP_H/2)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin pooling; sampled only in IDLE or DONE
busy  output  1  high from the cycle after start is accepted until the last write completes
done  output  1  high in DONE; held until the next accepted start or rst
rd_en  output  1  feature-map read strobe
rd_addr  output  RD_ADDR_W  feature-map read address, row-major (row*FMAP_W+col)
rd_data  input  DATA_W  signed read data; valid exactly one cycle after rd_en
wr_en  output  1  pooled-result write strobe, one cycle per result
wr_addr  output  WR_ADDR_W  result address, row-major (pr*(FMAP_W/2)+pc)
wr_data  output  DATA_W  signed pooled maximum

Behaviour:
- Reset: state=IDLE; busy, done, rd_en, wr_en = 0; rd_addr, wr_addr, wr_data = 0; window counters pr, pc = 0; accumulator = 0. A reset mid-operation aborts immediately: no further rd_en or wr_en, and no done.
- Output dims: OUT_W=FMAP_W/2, OUT_H=FMAP_H/2 (floor). An odd trailing row or column is never read.
- States: IDLE, RD0, RD1, RD2, RD3, WR, DONE.
- IDLE/DONE: if start=1, clear done and set pr=pc=0, busy=1, then go to RD0 next cycle. Otherwise stay; done stays 1 in DONE.
- RDk (k=0..3): rd_en=1; rd_addr=(2*pr+dr)*FMAP_W+(2*pc+dc), where (dr,dc) = (0,0),(0,1),(1,0),(1,1) for k=0..3.
- Accumulation (consumes rd_data from the previous cycle):
  - RD1: acc<=rd_data.
  - RD2, RD3: acc<=max(acc,rd_data), signed compare.
- WR: rd_en=0; wr_en=1; wr_addr=pr*OUT_W+pc; wr_data=max(acc,rd_data), signed.
- Ties: either operand is acceptable (values are equal).
- Next window after WR:
  - if pc<OUT_W-1: pc++, go to RD0.
  - else if pr<OUT_H-1: pc=0, pr++, go to RD0.
  - else: go to DONE, busy=0, done=1 (first asserted the cycle after the final WR).
- Timing: 5 cycles per window, no overlap between windows. First wr_en occurs 5 cycles after start is sampled. For 6x6: 9 writes; done rises 46 cycles after the start-sampling edge.
- start while busy (RD*/WR) is ignored; there is no queuing.
- rd_en and wr_en are never high in the same cycle. rd_addr, wr_addr and wr_data hold their last values when their strobe is low.
- No arithmetic is performed on data beyond compare, so no width growth or saturation.

Test Plan:
- Ramp: feature map[i]=i for i=0..35; pulse start -> writes addr0..8 = 7,9,11,19,21,23,31,33,35 in order; done=1 and busy=0 afterwards.
- Signed compare: every window {-5,-5,-5,-1}, with the -1 rotated through positions k=0..3 across windows -> every wr_data=-1 (0xFFFFFFFF); 0x80000000 vs 0x7FFFFFFF in one window -> 0x7FFFFFFF.
- Cycle timing: start sampled at edge T -> rd_en high T+1..T+4 with rd_addr 0,1,6,7; wr_en only at T+5 (addr 0); done first high at T+46; rd_en/wr_en never overlap.
- Start while busy: pulse start again at T+10 -> write sequence and done timing identical to the single-start run.
- Reset mid-op: assert rst for 1 cycle after the 4th write -> next cycle all outputs 0, state IDLE, no further writes. A new start then gives the full 9-write ramp result.
- Restart from DONE: start while done=1 -> done drops the next cycle, and the second run reproduces identical outputs.
